// File: rtl/fsm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : fsm_input_conditioner
// Description : Front-end conditioner for FSM inputs. Each channel passes
//               through a 2-flop synchroniser and then a stability counter.
//               The outputs are a clean registered level per channel, plus
//               one-cycle rise and fall pulses and a combined change flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_input_conditioner #(
    parameter int N_IN            = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic            clock,
    input  logic            reset_L,
    input  logic [N_IN-1:0] raw_in,
    input  logic            en,
    output logic [N_IN-1:0] level_out,
    output logic [N_IN-1:0] rise_out,
    output logic [N_IN-1:0] fall_out,
    output logic            any_change
);

    // A zero-cycle debounce has no meaning, so refuse to elaborate it.
    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("fsm_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    // Terminal count: the level flips on the edge where the counter already
    // holds this value and the synchronised input still disagrees.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]  sync_s1;
    logic [N_IN-1:0]  sync_s2;
    logic [CNT_W-1:0] cnt      [N_IN];
    logic [CNT_W-1:0] cnt_d    [N_IN];
    logic [N_IN-1:0]  level_d;
    logic [N_IN-1:0]  rise_d;
    logic [N_IN-1:0]  fall_d;
    logic             any_d;

    // Two-flop synchroniser; it runs independently of the enable.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= raw_in;
            sync_s2 <= sync_s1;
        end
    end

    // Next-state logic for the per-channel stability counters and levels.
    always_comb begin
        level_d = level_out;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = '0;
            if (en) begin
                if (sync_s2[i] == level_out[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt[i] == CNT_MAX) begin
                    level_d[i] = sync_s2[i];
                    rise_d[i]  = sync_s2[i];
                    fall_d[i]  = ~sync_s2[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt[i] + 1'b1;
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    // Register counters, levels and the single-cycle change pulses.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < N_IN; i++) begin
                cnt[i] <= '0;
            end
            level_out  <= '0;
            rise_out   <= '0;
            fall_out   <= '0;
            any_change <= 1'b0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                cnt[i] <= cnt_d[i];
            end
            level_out  <= level_d;
            rise_out   <= rise_d;
            fall_out   <= fall_d;
            any_change <= any_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fsm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_input_conditioner
// Description : Scoreboard bench for fsm_input_conditioner. A reference model
//               keeps a sliding window of the synchronised samples and flips
//               a channel when its last D samples were all enabled and all
//               disagreed with the current level. Expected outputs are queued
//               per clock edge and compared by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_input_conditioner;

    localparam int N = 3;
    localparam int D = 4;

    logic         clock;
    logic         reset_L;
    logic [N-1:0] raw_in;
    logic         en;
    logic [N-1:0] level_out;
    logic [N-1:0] rise_out;
    logic [N-1:0] fall_out;
    logic         any_change;

    int n_checks = 0;
    int n_fail   = 0;

    fsm_input_conditioner #(
        .N_IN           (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .raw_in    (raw_in),
        .en        (en),
        .level_out (level_out),
        .rise_out  (rise_out),
        .fall_out  (fall_out),
        .any_change(any_change)
    );

    typedef struct packed {
        logic         en;
        logic [N-1:0] s2;
    } samp_t;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         any;
    } exp_t;

    exp_t  sb[$];
    samp_t win[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: one expected output record per rising edge.
    initial begin : model
        logic [N-1:0] d1, d2, lvl, cur;
        exp_t         e;
        bit           all;
        d1  = '0;
        d2  = '0;
        lvl = '0;
        forever begin
            @(posedge clock);
            e = '0;
            if (!reset_L) begin
                d1  = '0;
                d2  = '0;
                lvl = '0;
                win.delete();
            end else begin
                // value the synchroniser presents at this edge was sampled two edges ago
                cur = d2;
                d2  = d1;
                d1  = raw_in;
                win.push_back('{en: en, s2: cur});
                if (win.size() > D) void'(win.pop_front());
                for (int ch = 0; ch < N; ch++) begin
                    if (win.size() == D) begin
                        all = 1'b1;
                        foreach (win[k])
                            if (!win[k].en || (win[k].s2[ch] == lvl[ch])) all = 1'b0;
                        if (all) begin
                            lvl[ch]    = ~lvl[ch];
                            e.rise[ch] = lvl[ch];
                            e.fall[ch] = ~lvl[ch];
                        end
                    end
                end
                e.lvl = lvl;
            end
            e.any = |(e.rise | e.fall);
            sb.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({level_out, rise_out, fall_out, any_change} !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got lvl=%b rise=%b fall=%b any=%b, want lvl=%b rise=%b fall=%b any=%b",
                             $time, level_out, rise_out, fall_out, any_change,
                             e.lvl, e.rise, e.fall, e.any);
                end
            end
        end
    end

    // Drive raw/en for n consecutive cycles, changing just after the rising edge.
    task automatic run(input logic [N-1:0] r, input logic e, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #2;
            raw_in = r;
            en     = e;
        end
    endtask

    // Assert reset mid-cycle, confirm outputs clear at once, then release.
    task automatic do_reset();
        @(negedge clock);
        #2;
        reset_L = 1'b0;
        #1;
        n_checks++;
        if ({level_out, rise_out, fall_out, any_change} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got lvl=%b rise=%b fall=%b any=%b, want all zero",
                     level_out, rise_out, fall_out, any_change);
        end
        repeat (2) @(posedge clock);
        #2;
        reset_L = 1'b1;
    endtask

    // Count edges after release until level_out reaches want (bounded).
    task automatic check_latency(input string name, input logic [N-1:0] want, input int edges);
        int seen;
        seen = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            if (level_out == want) begin
                seen = k;
                break;
            end
        end
        n_checks++;
        if (seen != edges) begin
            n_fail++;
            $display("FAIL %s: level reached after %0d edges (-1 = never), want %0d", name, seen, edges);
        end
    endtask

    initial begin : stimulus
        raw_in  = '0;
        en      = 1'b1;
        reset_L = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_L = 1'b1;
        run(3'b000, 1'b1, 8);

        // Reset with all inputs high, then full latency after release.
        run(3'b111, 1'b1, 3);
        do_reset();
        check_latency("reset_release_latency", 3'b111, 6);
        run(3'b111, 1'b1, 4);
        run(3'b000, 1'b1, 10);

        // Clean edge on channel 0.
        run(3'b001, 1'b1, 10);
        run(3'b000, 1'b1, 10);

        // Glitch reject (3 cycles) then accept (4 cycles) on channel 1.
        run(3'b010, 1'b1, 3);
        run(3'b000, 1'b1, 10);
        run(3'b010, 1'b1, 4);
        run(3'b000, 1'b1, 12);

        // Simultaneous flip on channels 0 and 2.
        run(3'b101, 1'b1, 10);
        run(3'b000, 1'b1, 10);

        // Enable held low while channel 2 rises, then enabled.
        run(3'b100, 1'b0, 10);
        run(3'b100, 1'b1, 10);
        run(3'b000, 1'b1, 10);

        // Reset in the middle of a count on channel 0.
        run(3'b001, 1'b1, 5);
        do_reset();
        check_latency("reset_midcount_latency", 3'b001, 6);
        run(3'b000, 1'b1, 10);

        // Randomised segment: slow and bouncy patterns with sporadic enable drops.
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] r;
            logic         e;
            r = raw_in;
            if ($urandom_range(0, 5) == 0) r = N'($urandom);
            e = ($urandom_range(0, 15) != 0);
            run(r, e, 1);
        end
        run(3'b000, 1'b1, 10);

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsm_input_conditioner.md
Name: fsm_input_conditioner

Overview:
- Front-end stage that feeds the `$fsm`-generated controllers (e.g. a 3-input Moore/Mealy FSM with inputs in1..in3).
- Takes raw asynchronous or bouncy inputs and synchronises each into the clock domain with a 2-flop synchroniser.
- Debounces each channel with a per-channel stability counter.
- Presents clean levels plus one-cycle rise/fall pulses, so FSM transition conditions never see glitches or metastable values.

Parameters:
- N_IN, 3: number of independent input channels.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised value must differ from the current level before the level flips. Must be >= 1; elaboration error otherwise.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): counter width. Derived; not to be overridden.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset_L, input, 1: asynchronous, active-low reset.
- raw_in, input, N_IN: unsynchronised raw inputs.
- en, input, 1: conditioning enable (synchronous).
- level_out, output, N_IN: debounced, registered level per channel; drives FSM inputs.
- rise_out, output, N_IN: one-cycle pulse on each 0->1 level change.
- fall_out, output, N_IN: one-cycle pulse on each 1->0 level change.
- any_change, output, 1: OR of rise_out | fall_out. Registered; asserted in the same cycle as the pulses.

Behaviour:
- Reset (reset_L=0, asynchronous): sync stage 1 and stage 2 = 0, all counters = 0, level_out = 0, rise_out = 0, fall_out = 0, any_change = 0. Release is synchronous to the next rising edge; no output toggles during the first cycle after release.
- Synchroniser: s1[i] <= raw_in[i]; s2[i] <= s1[i]. It runs every cycle regardless of en. Only s2 is used downstream.
- Per-channel debounce counter, evaluated each edge when en=1:
  - If s2[i] == level_out[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: level_out[i] <= s2[i], cnt[i] <= 0, and rise_out[i] / fall_out[i] <= 1 according to direction.
  - Else: cnt[i] <= cnt[i]+1.
- Pulses are registered. They are high for exactly one cycle, in the same cycle level_out shows the new value, and deassert on the following edge unless another flip occurs.
- Latency:
  - raw_in changes and stays stable before edge t, so s1 captures it at edge t and s2 at edge t+1.
  - level_out flips at edge t+1+DEBOUNCE_CYCLES.
  - With default 4: flip at edge t+5. With DEBOUNCE_CYCLES=1: flip at t+2.
- Glitch rejection: any s2 excursion shorter than DEBOUNCE_CYCLES cycles resets the counter on return and never reaches level_out.
- Channels are fully independent. Simultaneous flips on several channels in one cycle each assert their own pulse; any_change is asserted once.
- en=0: cnt held at 0, level_out frozen, rise_out / fall_out / any_change forced to 0 on the next edge. Counting restarts from 0 when en returns to 1, with full DEBOUNCE_CYCLES required.
- Reset mid-count: all state clears immediately. A partially counted transition is discarded, and an input still held afterwards requires the full latency from reset release.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- No combinational path from raw_in or en to any output.

Test Plan:
- Reset: assert reset_L=0 mid-clock with raw_in=3'b111 -> all outputs 0 immediately, asynchronous to the clock. After release with raw_in still 3'b111 -> level_out=3'b111 exactly 6 edges after release (D=4). rise_out=3'b111 and any_change=1 for one cycle only.
- Clean edge: raw_in[0] 0->1 before edge t, held -> level_out[0]=1 at edge t+5; rise_out[0] high for cycle t+5..t+6 only. Raw back to 0 -> fall_out[0] pulses 5 edges later.
- Glitch reject/accept: raw_in[1] high for 3 cycles then low -> level_out[1] stays 0, no pulses. Repeat with high for 4 cycles -> level_out[1]=1 at +5 and returns to 0 after a further 5 edges, with one rise and one fall pulse.
- Simultaneous: raw_in 3'b000 -> 3'b101 in one cycle -> level_out=3'b101 and rise_out=3'b101 in the same cycle; any_change=1 for exactly one cycle; channel 1 unaffected.
- Enable: hold en=0 while raw_in[2] rises and stays high for 10 cycles -> level_out[2]=0, no pulses. Raise en -> level_out[2]=1 exactly 4 edges after en=1 is sampled.
- Reset mid-count: raw_in[0] rises, assert reset_L after 3 counted cycles, release with raw still high -> no early flip; level_out[0]=1 exactly 6 edges after release.
